trng_ehr_fetch: RTL and testbench

TRNG_EHR_FETCH -- requirements
Module: trng_ehr_fetch

---
 rtl/trng_ehr_fetch.sv | 125 ++++++++++++
 tb/tb_trng_ehr_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/trng_ehr_fetch.sv
// trng_ehr_fetch: APB master that polls a TRNG status register and fetches the EHR words of one sample
// Ports: rng_clk / rst_n clock and asynchronous active-low reset; fetch_en level enable;
//   psel/penable/pwrite/paddr (out) and prdata/pready/pslverr (in) form the APB master;
//   rnd_data/rnd_valid/rnd_ready deliver a full sample; fetch_err pulses on a slave error;
//   fetch_busy is high whenever the block is not idle.
module trng_ehr_fetch #(
  parameter int          NUM_WORDS   = 6,
  parameter logic [11:0] EHR_BASE    = 12'h114,
  parameter logic [11:0] STATUS_ADDR = 12'h104,
  parameter int          POLL_GAP    = 8
) (
  input  logic                      rng_clk,
  input  logic                      rst_n,
  input  logic                      fetch_en,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [11:0]               paddr,
  input  logic [31:0]               prdata,
  input  logic                      pready,
  input  logic                      pslverr,
  output logic [32*NUM_WORDS-1:0]   rnd_data,
  output logic                      rnd_valid,
  input  logic                      rnd_ready,
  output logic                      fetch_err,
  output logic                      fetch_busy
);
  localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
  typedef enum logic [2:0] {IDLE, GAP, POLL_SETUP, POLL_ACCESS, RD_SETUP, RD_ACCESS, HOLD} state_t;
  state_t state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic [IW-1:0] idx_q, idx_d, idx_nxt;
  logic [11:0] paddr_q, paddr_d;
  logic [32*NUM_WORDS-1:0] buf_q, buf_d, rnd_data_q, rnd_data_d;
  logic err_q, err_d;
  assign idx_nxt    = idx_q + IW'(1);
  assign psel       = (state_q == POLL_SETUP) || (state_q == POLL_ACCESS) ||
                      (state_q == RD_SETUP) || (state_q == RD_ACCESS);
  assign penable    = (state_q == POLL_ACCESS) || (state_q == RD_ACCESS);
  assign pwrite     = 1'b0;
  assign paddr      = paddr_q;
  assign rnd_data   = rnd_data_q;
  assign rnd_valid  = state_q == HOLD;
  assign fetch_err  = err_q;
  assign fetch_busy = state_q != IDLE;
  // Words are gathered in a shadow buffer and published to rnd_data only with the
  // last capture, so an aborted sample never disturbs the previously delivered one.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    idx_d      = idx_q;
    paddr_d    = paddr_q;
    buf_d      = buf_q;
    rnd_data_d = rnd_data_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (fetch_en) begin
        state_d = GAP;
        gap_d   = 8'(POLL_GAP);
      end
      GAP:
        if (!fetch_en) state_d = IDLE;
        else if (gap_q == 8'd0) begin
          state_d = POLL_SETUP;
          paddr_d = STATUS_ADDR;
        end else gap_d = gap_q - 8'd1;
      POLL_SETUP: state_d = POLL_ACCESS;
      POLL_ACCESS: if (pready) begin
        if (pslverr) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (prdata[0]) begin
          state_d = RD_SETUP;
          idx_d   = '0;
          paddr_d = EHR_BASE;
        end else if (fetch_en) begin
          state_d = GAP;
          gap_d   = 8'(POLL_GAP);
        end else state_d = IDLE;
      end
      RD_SETUP: state_d = RD_ACCESS;
      RD_ACCESS: if (pready) begin
        if (pslverr) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          buf_d[{idx_q, 5'b0} +: 32] = prdata;
          if (idx_q == LAST) begin
            state_d    = HOLD;
            rnd_data_d = buf_d;
          end else begin
            state_d = RD_SETUP;
            idx_d   = idx_nxt;
            paddr_d = EHR_BASE + 12'({idx_nxt, 2'b00});
          end
        end
      end
      HOLD: if (rnd_ready) begin
        state_d = fetch_en ? GAP : IDLE;
        gap_d   = 8'(POLL_GAP);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      idx_q      <= '0;
      paddr_q    <= '0;
      buf_q      <= '0;
      rnd_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      paddr_q    <= paddr_d;
      buf_q      <= buf_d;
      rnd_data_q <= rnd_data_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_trng_ehr_fetch.sv
// tb_trng_ehr_fetch: directed table plus randomized samples against an APB slave model and expected transaction lists
module tb_trng_ehr_fetch;
  localparam int NW = 6;
  localparam int BASE = 'h114;
  localparam int STAT = 'h104;
  localparam int GAP = 8;
  localparam int DW = 32 * NW;
  logic rng_clk = 0, rst_n = 0, fetch_en = 0, rnd_ready = 0, pready = 0, pslverr = 0;
  logic psel, penable, pwrite, rnd_valid, fetch_err, fetch_busy;
  logic [11:0] paddr;
  logic [31:0] prdata = '0;
  logic [DW-1:0] rnd_data;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] words [NW];
  int zero_left = 0, wait_word = -1, wait_left = 0, err_word = -1;
  bit poll_err = 0, hold_chk = 0;
  logic [11:0] hold_addr = '0;
  int log_q[$];
  int idle = 0, last_gap = -1;
  logic [DW-1:0] prev_data = '0;

  typedef struct {int z; int ww; int wn; int ew; int dw; bit exp_err; int exp_nx; string tag;} vec_t;
  vec_t tbl[6];

  trng_ehr_fetch dut (
    .rng_clk(rng_clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .fetch_err(fetch_err), .fetch_busy(fetch_busy)
  );

  always #5 rng_clk = ~rng_clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // APB slave: responds on the negedge so the DUT sees the reply at the next rising edge
  always @(negedge rng_clk) begin
    if (hold_chk) chk("wait_stable", {psel, penable, paddr}, {2'b11, hold_addr});
    hold_chk = 0;
    if (psel) chk("pwrite_zero", pwrite, 0);
    if (!psel) idle++;
    else begin
      if (!penable && int'(paddr) == STAT && idle > 0) last_gap = idle;
      idle = 0;
    end
    pready = 0; pslverr = 0; prdata = $urandom;
    if (rst_n && psel && penable) begin
      if (int'(paddr) == BASE + 4 * wait_word && wait_left > 0) begin
        wait_left--;
        hold_chk = 1;
        hold_addr = paddr;
      end else begin
        pready = 1;
        log_q.push_back(int'(paddr));
        if (int'(paddr) == STAT) begin
          prdata[0] = (zero_left == 0);
          pslverr = poll_err;
          if (zero_left > 0) zero_left--;
        end else begin
          int k;
          k = (int'(paddr) - BASE) / 4;
          if (k >= 0 && k < NW) begin
            prdata = words[k];
            pslverr = (k == err_word);
          end
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 100 && fetch_busy; t++) @(negedge rng_clk);
    chk({tag, "_idle"}, fetch_busy, 0);
  endtask

  // One sample attempt; expected transactions/outcome come from the slave scenario,
  // not from the DUT: z not-ready polls, then words up to an error or all of them.
  task automatic run(input int z, input int ww, input int wn, input int ew, input int dw,
                     input bit exp_err, input int exp_nx, input string tag);
    logic [DW-1:0] exp_d;
    int exp_a[$];
    bit done, vseen;
    int errs, nx;
    done = 0; vseen = 0; errs = 0;
    for (int k = 0; k < NW; k++) begin
      words[k] = $urandom;
      exp_d[32*k +: 32] = words[k];
    end
    zero_left = (ew == -2) ? 0 : z;
    wait_word = ww; wait_left = wn; err_word = ew; poll_err = (ew == -2);
    log_q.delete(); last_gap = -1;
    for (int i = 0; i < ((ew == -2) ? 1 : z + 1); i++) exp_a.push_back(STAT);
    if (ew != -2)
      for (int k = 0; k < NW && (ew < 0 || k <= ew); k++) exp_a.push_back(BASE + 4 * k);
    nx = (exp_nx < 0) ? exp_a.size() : exp_nx;
    fetch_en = 1; rnd_ready = 0;
    for (int t = 0; t < 800 && !done; t++) begin
      @(negedge rng_clk);
      if (dw >= 0 && psel && int'(paddr) == BASE + 4 * dw) fetch_en = 0;
      if (fetch_err) begin errs++; fetch_en = 0; done = 1; end
      if (rnd_valid) begin vseen = 1; done = 1; end
    end
    chk({tag, "_done"}, done, 1);
    fetch_en = 0;
    if (exp_err) begin
      repeat (3) begin
        @(negedge rng_clk);
        if (fetch_err) errs++;
        if (rnd_valid) vseen = 1;
      end
      chk({tag, "_err_pulse"}, errs, 1);
      chk({tag, "_no_valid"}, vseen, 0);
      chk({tag, "_data_kept"}, rnd_data, prev_data);
    end else begin
      chk({tag, "_no_err"}, errs, 0);
      chk({tag, "_data"}, rnd_data, exp_d);
      rnd_ready = 1;
      @(negedge rng_clk);
      rnd_ready = 0;
      chk({tag, "_valid_drop"}, rnd_valid, 0);
      prev_data = exp_d;
    end
    wait_idle(tag);
    chk({tag, "_psel_low"}, psel, 0);
    chk({tag, "_nx"}, log_q.size(), nx);
    for (int i = 0; i < exp_a.size() && i < log_q.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), log_q[i], exp_a[i]);
    if (z >= 1 && ew != -2) chk({tag, "_gap"}, last_gap, GAP + 1);
  endtask

  initial begin
    logic [DW-1:0] exp_d;
    bit got, ok;
    int k, z, ww, ew, dw;
    tbl[0] = '{2, -1, 0, -1, -1, 0, 9, "ehr_basic"};
    tbl[1] = '{0,  2, 3, -1, -1, 0, 7, "wait_w2"};
    tbl[2] = '{0, -1, 0,  4, -1, 1, 6, "err_w4"};
    tbl[3] = '{0, -1, 0, -2, -1, 1, 1, "err_poll"};
    tbl[4] = '{1, -1, 0, -1,  3, 0, 8, "drop_w3"};
    tbl[5] = '{0,  5, 2,  0, -1, 1, 2, "err_w0"};
    repeat (3) @(negedge rng_clk);
    chk("rst_ctrl", {psel, penable, pwrite, rnd_valid, fetch_err, fetch_busy}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_data", rnd_data, 0);
    rst_n = 1;
    repeat (2) @(negedge rng_clk);
    chk("idle_no_en", fetch_busy, 0);
    foreach (tbl[i]) run(tbl[i].z, tbl[i].ww, tbl[i].wn, tbl[i].ew, tbl[i].dw,
                         tbl[i].exp_err, tbl[i].exp_nx, tbl[i].tag);
    for (int i = 0; i < 12; i++) begin
      z = $urandom_range(0, 2);
      k = $urandom_range(0, NW);
      ww = (k == NW) ? -1 : k;
      ew = -1;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, NW);
        ew = (k == NW) ? -2 : k;
        if (ew == -2) z = 0;
      end
      dw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NW - 1) : -1;
      run(z, ww, $urandom_range(1, 3), ew, dw, ew != -1, -1, $sformatf("rnd%0d", i));
    end
    // downstream back-pressure: sample held with no APB traffic, then re-poll after the gap
    for (int j = 0; j < NW; j++) begin
      words[j] = $urandom;
      exp_d[32*j +: 32] = words[j];
    end
    zero_left = 0; wait_word = -1; err_word = -1; poll_err = 0; log_q.delete();
    fetch_en = 1; rnd_ready = 0; got = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge rng_clk);
      got = rnd_valid;
    end
    chk("hold_valid", got, 1);
    ok = 1;
    repeat (20) begin
      @(negedge rng_clk);
      if (!rnd_valid || psel || rnd_data !== exp_d) ok = 0;
    end
    chk("hold_stable", ok, 1);
    zero_left = 1000; rnd_ready = 1; k = 0;
    do begin
      @(negedge rng_clk);
      rnd_ready = 0;
      k++;
      if (k == 1) chk("hold_valid_drop", rnd_valid, 0);
    end while (!psel && k < 60);
    chk("regap_cycles", k, GAP + 2);
    chk("regap_addr", paddr, STAT);
    fetch_en = 0; prev_data = exp_d;
    wait_idle("regap");
    // asynchronous reset in the middle of an EHR read
    zero_left = 0; log_q.delete(); fetch_en = 1; got = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge rng_clk);
      got = psel && penable && paddr == 12'h11C;
    end
    chk("rst_mid_found", got, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_ctrl", {psel, penable, pwrite, rnd_valid, fetch_err, fetch_busy}, 0);
    chk("rst_mid_paddr", paddr, 0);
    chk("rst_mid_data", rnd_data, 0);
    fetch_en = 0;
    @(negedge rng_clk);
    rst_n = 1; zero_left = 1000; log_q.delete(); fetch_en = 1;
    for (int t = 0; t < 100 && log_q.size() == 0; t++) @(negedge rng_clk);
    chk("rst_repoll_cnt", log_q.size() > 0, 1);
    if (log_q.size() > 0) chk("rst_repoll_addr", log_q[0], STAT);
    fetch_en = 0;
    wait_idle("rst_end");
    zero_left = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
